pipelined_be_dp_ram: RTL and testbench

PIPELINED_BE_DP_RAM -- requirements
Module: pipelined_be_dp_ram

---
 rtl/pipelined_be_dp_ram_pkg.sv | 12 +
 rtl/pipelined_be_dp_ram_if.sv | 28 ++
 rtl/pipelined_be_dp_ram_bank.sv | 31 +++
 rtl/pipelined_be_dp_ram.sv | 130 +++++++++++++
 tb/tb_pipelined_be_dp_ram.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/pipelined_be_dp_ram_pkg.sv
// Shared types and constants for the pipelined byte-enable dual-port RAM.
package ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int MAX_RD_LATENCY = 4;
  localparam int BYTE_W         = 8;

endpackage

// File: rtl/pipelined_be_dp_ram_if.sv
// Write/read bus of the pipelined byte-enable dual-port RAM.
interface pipelined_be_dp_ram_if #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 512
);
  localparam int AW = $clog2(DEPTH);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DWIDTH-1:0]     wr_data;
  logic [DWIDTH/8-1:0]   wr_be;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [DWIDTH-1:0]     rd_data;
  logic                  rd_valid;
  logic                  init_done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_done
  );

endinterface

// File: rtl/pipelined_be_dp_ram_bank.sv
// Storage array: one byte-enabled write port, one registered read port, no reset.
module dp_ram_bank
  import ram_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 512
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DWIDTH-1:0]          wdata,
  input  logic [DWIDTH/BYTE_W-1:0]   wbe,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DWIDTH-1:0]          rdata
);
  localparam int NB = DWIDTH / BYTE_W;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Read-before-write: a same-address read captures the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipelined_be_dp_ram.sv
// Pipelined byte-enable dual-port RAM with power-up clear FSM.
// Define RAM_BYPASS_EN to forward same-cycle same-address write bytes to the read.
module pipelined_be_dp_ram
  import ram_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int DEPTH      = 512,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_be_dp_ram_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DWIDTH / BYTE_W;

  generate
    if (DWIDTH < BYTE_W || (DWIDTH % BYTE_W) != 0) begin : g_bad_dwidth
      $fatal(1, "pipelined_be_dp_ram: DWIDTH=%0d must be a non-zero multiple of 8", DWIDTH);
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "pipelined_be_dp_ram: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
      $fatal(1, "pipelined_be_dp_ram: RD_LATENCY=%0d outside 1..4", RD_LATENCY);
    end
  endgenerate

  ram_state_e             state;
  logic [AW-1:0]          clr_addr;
  logic                   init_done_q;
  logic                   wr_act;
  logic                   rd_acc;
  logic                   bank_we;
  logic [AW-1:0]          bank_waddr;
  logic [DWIDTH-1:0]      bank_wdata;
  logic [NB-1:0]          bank_wbe;
  logic [DWIDTH-1:0]      bank_rdata;
  logic [DWIDTH-1:0]      s1_data;
  logic [DWIDTH-1:0]      last_data;
  logic [DWIDTH-1:0]      hold_q;
  logic [RD_LATENCY-1:0]  vld;

  assign wr_act = (state == READY) & bus.wr_en;
  assign rd_acc = (state == READY) & bus.rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      clr_addr    <= '0;
      init_done_q <= 1'b0;
    end else if (state == INIT) begin
      if (clr_addr == AW'(DEPTH - 1)) begin
        state       <= READY;
        init_done_q <= 1'b1;
      end
      clr_addr <= clr_addr + 1'b1;
    end
  end

  // The clear sweep owns the write port for the whole of INIT.
  assign bank_we    = (state == INIT) | wr_act;
  assign bank_waddr = (state == INIT) ? clr_addr : bus.wr_addr;
  assign bank_wdata = (state == INIT) ? '0 : bus.wr_data;
  assign bank_wbe   = (state == INIT) ? '1 : bus.wr_be;

  dp_ram_bank #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .wbe   (bank_wbe),
    .re    (rd_acc),
    .raddr (bus.rd_addr),
    .rdata (bank_rdata)
  );

`ifdef RAM_BYPASS_EN
  logic              byp_hit;
  logic [DWIDTH-1:0] byp_data;
  logic [NB-1:0]     byp_be;

  always_ff @(posedge clk) begin
    byp_hit  <= rd_acc & wr_act & (bus.wr_addr == bus.rd_addr);
    byp_data <= bus.wr_data;
    byp_be   <= bus.wr_be;
  end

  always_comb begin
    s1_data = bank_rdata;
    for (int b = 0; b < NB; b++) begin
      if (byp_hit && byp_be[b]) s1_data[b*BYTE_W +: BYTE_W] = byp_data[b*BYTE_W +: BYTE_W];
    end
  end
`else
  assign s1_data = bank_rdata;
`endif

  generate
    if (RD_LATENCY > 1) begin : g_pipe
      logic [DWIDTH-1:0] dq [2:RD_LATENCY];
      always_ff @(posedge clk) begin
        dq[2] <= s1_data;
        for (int k = 3; k <= RD_LATENCY; k++) dq[k] <= dq[k-1];
      end
      assign last_data = dq[RD_LATENCY];
    end else begin : g_no_pipe
      assign last_data = s1_data;
    end
  endgenerate

  // vld[0] qualifies the bank output; the top bit is the outgoing rd_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      hold_q <= '0;
    end else begin
      vld <= (vld << 1) | RD_LATENCY'(rd_acc);
      if (vld[RD_LATENCY-1]) hold_q <= last_data;
    end
  end

  assign bus.rd_valid  = vld[RD_LATENCY-1] & ~rst;
  assign bus.rd_data   = rst ? '0 : (vld[RD_LATENCY-1] ? last_data : hold_q);
  assign bus.init_done = init_done_q & ~rst;

endmodule

// File: tb/tb_pipelined_be_dp_ram.sv
// Randomized bench for pipelined_be_dp_ram against a cycle-indexed reference model.
module tb_pipelined_be_dp_ram;
  localparam int DW  = 64;
  localparam int DP  = 16;
  localparam int LAT = 3;
  localparam int AW  = 4;

  typedef struct {
    int          due;
    logic [63:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_be_dp_ram_if #(.DWIDTH(DW), .DEPTH(DP)) bus ();

  pipelined_be_dp_ram #(
    .DWIDTH     (DW),
    .DEPTH      (DP),
    .RD_LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rd_t         pend [$];
  logic [63:0] mem_m [DP];
  logic [63:0] hold_m;
  int          cyc;
  int          low_start;
  int          n_chk;
  int          n_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                        input logic [7:0] be);
    for (int b = 0; b < 8; b++) if (be[b]) o[b*8 +: 8] = d[b*8 +: 8];
    return o;
  endfunction

  // Check outputs of cycle cyc mid-cycle, then advance the model past its closing edge.
  task automatic tick();
    logic        rdy;
    logic        ev;
    logic [63:0] ed;
    logic [63:0] rv;
    @(negedge clk);
    rdy = !rst && (cyc >= low_start + DP);
    ev  = !rst && pend.size() > 0 && pend[0].due == cyc;
    ed  = rst ? 64'h0 : (ev ? pend[0].data : hold_m);
    chk("init_done", 64'(bus.init_done), 64'(rdy));
    chk("rd_valid", 64'(bus.rd_valid), 64'(ev));
    chk("rd_data", bus.rd_data, ed);
    if (rst) begin
      pend.delete();
      hold_m    = '0;
      low_start = cyc + 1;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else begin
      if (ev) begin
        hold_m = pend[0].data;
        void'(pend.pop_front());
      end
      if (rdy && bus.rd_en) begin
        rv = mem_m[bus.rd_addr];
`ifdef RAM_BYPASS_EN
        if (bus.wr_en && bus.wr_addr == bus.rd_addr) rv = merge(rv, bus.wr_data, bus.wr_be);
`endif
        pend.push_back('{cyc + LAT, rv});
      end
      if (rdy && bus.wr_en) mem_m[bus.wr_addr] = merge(mem_m[bus.wr_addr], bus.wr_data, bus.wr_be);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input bit r, input bit we, input int wa, input logic [63:0] wd,
                       input logic [7:0] be, input bit re, input int ra);
    rst         = r;
    bus.wr_en   = we;
    bus.wr_addr = AW'(wa);
    bus.wr_data = wd;
    bus.wr_be   = be;
    bus.rd_en   = re;
    bus.rd_addr = AW'(ra);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 64'h0, 8'h00, 0, 0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    n_chk = 0; n_bad = 0; cyc = 0; low_start = 0; hold_m = '0;
    foreach (mem_m[i]) mem_m[i] = '0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.rd_en = 0; bus.rd_addr = '0;
    @(posedge clk);
    #1;

    repeat (3) drive(1, 1, 1, rnd64(), 8'hFF, 1, 1);

    // Traffic during the whole clear sweep must be ignored.
    for (int i = 0; i < DP; i++) drive(0, 1, 2, rnd64(), 8'hFF, 1, i);
    drive(0, 0, 0, 64'h0, 8'h00, 1, 2);
    drive(0, 0, 0, 64'h0, 8'h00, 1, 5);
    idle(LAT + 1);

    drive(0, 1, 3, 64'h1122334455667788, 8'hFF, 0, 0);
    drive(0, 1, 3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0);
    drive(0, 0, 0, 64'h0, 8'h00, 1, 3);
    drive(0, 1, 3, rnd64(), 8'h00, 0, 0);
    drive(0, 0, 0, 64'h0, 8'h00, 1, 3);
    idle(LAT + 1);

    for (int i = 0; i < 8; i++) drive(0, 1, i, rnd64(), 8'hFF, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 64'h0, 8'h00, 1, i);
    idle(LAT + 2);

    drive(0, 1, 7, 64'h0, 8'hFF, 0, 0);
    drive(0, 1, 7, 64'hDEAD, 8'hFF, 1, 7);
    drive(0, 0, 0, 64'h0, 8'h00, 1, 7);
    idle(LAT + 1);

    // Reset with reads in flight, then again mid-clear.
    drive(0, 0, 0, 64'h0, 8'h00, 1, 1);
    drive(0, 0, 0, 64'h0, 8'h00, 1, 2);
    drive(1, 0, 0, 64'h0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 4, rnd64(), 8'hFF, 1, 4);
    drive(1, 0, 0, 64'h0, 8'h00, 1, 4);
    for (int i = 0; i < DP + 4; i++) drive(0, 1, 4, rnd64(), 8'hFF, 1, 4);
    idle(LAT + 1);

    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, DP - 1),
            rnd64(), 8'($urandom_range(0, 255)), $urandom_range(0, 9) < 6,
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, DP - 1));
    end
    idle(LAT + 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
